mac_unit_vert_seq: RTL
======================

Name: mac_unit_vert_seq

Overview:
- Parametrised, self-sequencing successor of the 16-lane vertical bit-serial MAC.
- Accepts one activation tile via a valid/ready handshake and computes per-group activation sums internally; no external sum_act input.
- Then consumes W_BITS weight-column descriptors (MSB first) on a second handshake, accumulating shifted partial sums in a two-stage pipeline.
- Presents the accumulator on a valid/ready result port; sits between the column-descriptor decoder and the output writeback.

Parameters:
- DATA_WIDTH, 8: activation width, signed.
- VEC_LENGTH, 16: activations per tile.
- GROUP_SIZE, 8: activations per group. Must divide VEC_LENGTH and be even. NUM_GROUPS = VEC_LENGTH/GROUP_SIZE.
- W_BITS, 8: weight bit columns per tile.
- ACC_WIDTH, DATA_WIDTH+16: accumulator width.
- RESULT_WIDTH, 2*DATA_WIDTH: truncated result width.
- SEL_WIDTH, $clog2(GROUP_SIZE/2+1): selector index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- act_valid  in  1  tile offer.
- act_ready  out  1  high only in IDLE.
- act_in  in  signed [DATA_WIDTH-1:0] x VEC_LENGTH  tile activations.
- accum_init  in  signed ACC_WIDTH  accumulator seed, captured with the tile.
- col_valid  in  1  column descriptor offer.
- col_ready  out  1  high only in COL.
- col_sel  in  [SEL_WIDTH-1:0] x VEC_LENGTH/2  window offset per selector.
- col_val  in  1 x VEC_LENGTH/2  selector enable.
- col_skip_zero  in  1 x NUM_GROUPS  1: use selected sum; 0: use group_sum minus selected sum.
- col_en_mul  in  1  enable constant-multiplier path.
- col_mul_const  in  signed 3  multiplier constant.
- col_shift_mul  in  1  shift multiplier product by 3.
- res_valid  out  1  result available.
- res_ready  in  1  result accepted.
- accum_out  out  signed ACC_WIDTH  full accumulator.
- result  out  signed RESULT_WIDTH  accum_out[ACC_WIDTH-1 -: RESULT_WIDTH].
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE, accumulator=0, pipeline valid=0, res_valid=0, col_ready=0, act_ready=1 in the following cycle.
- FSM IDLE -> LOAD: on act_valid&act_ready. Latch act_in and accum_init; accumulator<=accum_init; column counter c<=W_BITS-1.
- FSM LOAD (1 cycle): register group_sum[g] = sum of the group's GROUP_SIZE acts, width DATA_WIDTH+$clog2(GROUP_SIZE). Then -> COL.
- FSM COL: each col_valid&col_ready beat uses current c, then c decrements. Beat at c==0 -> DRAIN. col_valid low is a bubble: no accumulate, c holds.
- FSM DRAIN: last term accumulates -> DONE.
- FSM DONE: res_valid=1. result/accum_out stable until res_ready. Handshake -> IDLE, res_valid=0.
- Selector k (0..GROUP_SIZE/2-1) of group g picks act[g*GROUP_SIZE+k+sel]. Contributes 0 if val=0 or sel>GROUP_SIZE/2.
- psum[g] = sum of group g selectors. true[g] = skip_zero ? psum[g] : group_sum[g]-psum[g]. total = sum of true[g].
- Column term: term = (c==W_BITS-1 ? -total : total) <<< c.
- Multiplier term: mul = (en_mul ? sum of group_sum : 0) * mul_const, then <<<3 if shift_mul. mul is added in the same beat.
- Stage 1 registers term+mul with a valid bit. Stage 2 sign-extends to ACC_WIDTH and adds into the accumulator.
- All arithmetic is signed and wraps modulo 2^ACC_WIDTH.
- Latency: final beat accepted at edge T -> accumulated at T+1 -> res_valid high from edge T+2.
- Simultaneous res_valid&res_ready with act_valid: the tile is not accepted that cycle (act_ready=0 in DONE); it is accepted the next cycle.
- col_valid outside COL and act_valid outside IDLE are ignored.
- Reset mid-operation aborts the tile: in-flight pipeline terms are discarded, no partial result is presented.

Test Plan:
- Reset with random inputs driven -> accum_out=0, res_valid=0, col_ready=0; act_ready=1 the cycle after reset deasserts.
- Acts all 1, accum_init=0; 8 columns with val all 1, sel 0, skip_zero 1, en_mul 0 -> total 8 per column, 8*127-8*128 = -8; accum_out=24'hFFFFF8, result=16'hFFFF.
- Acts all 1; only column c=3 has skip_zero=0 with val all 0, other columns contribute 0 -> accum_out=16<<3=128.
- Acts all 2, accum_init=1000; column c=0 en_mul=1, mul_const=-3, shift_mul=1, val all 0, skip_zero 1 -> 32*-3*8=-768; accum_out=232.
- Backpressure: repeat scenario 2 with col_valid toggled every other cycle and res_ready low for 5 cycles -> accum_out=-8; result stable while res_valid; act_ready=0 throughout.
- Reset asserted after 3 column beats -> next cycle IDLE, accum_out=0, res_valid=0. A following scenario-3 tile gives 128.

Source files
------------

// File: rtl/mac_unit_vert_seq.sv
// Self-sequencing vertical bit-serial MAC: loads an activation tile, folds W_BITS
// weight-bit columns MSB first through a two-stage pipeline, then presents the sum.
module mac_unit_vert_seq #(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int GROUP_SIZE   = 8,
    parameter int W_BITS       = 8,
    parameter int ACC_WIDTH    = DATA_WIDTH + 16,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH,
    parameter int SEL_WIDTH    = $clog2(GROUP_SIZE / 2 + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  act_valid,
    output logic                                  act_ready,
    input  logic signed [DATA_WIDTH-1:0]          act_in [VEC_LENGTH],
    input  logic signed [ACC_WIDTH-1:0]           accum_init,
    input  logic                                  col_valid,
    output logic                                  col_ready,
    input  logic        [SEL_WIDTH-1:0]           col_sel [VEC_LENGTH/2],
    input  logic        [VEC_LENGTH/2-1:0]        col_val,
    input  logic        [VEC_LENGTH/GROUP_SIZE-1:0] col_skip_zero,
    input  logic                                  col_en_mul,
    input  logic signed [2:0]                     col_mul_const,
    input  logic                                  col_shift_mul,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic signed [ACC_WIDTH-1:0]           accum_out,
    output logic signed [RESULT_WIDTH-1:0]        result,
    output logic                                  busy
);

    localparam int NUM_GROUPS = VEC_LENGTH / GROUP_SIZE;
    localparam int HALF       = GROUP_SIZE / 2;
    localparam int GSUM_WIDTH = DATA_WIDTH + $clog2(GROUP_SIZE);
    localparam int CNT_WIDTH  = (W_BITS > 1) ? $clog2(W_BITS) : 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COL   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                        state_r;
    logic signed [DATA_WIDTH-1:0]  act_r   [VEC_LENGTH];
    logic signed [GSUM_WIDTH-1:0]  gsum_r  [NUM_GROUPS];
    logic signed [GSUM_WIDTH-1:0]  gsum_s  [NUM_GROUPS];
    logic        [CNT_WIDTH-1:0]   cnt_r;
    logic signed [ACC_WIDTH-1:0]   accum_r;
    logic signed [ACC_WIDTH-1:0]   pipe_term_r;
    logic                          pipe_valid_r;
    logic                          act_ready_r;
    logic                          col_ready_r;
    logic                          res_valid_r;
    logic                          busy_r;

    logic signed [ACC_WIDTH-1:0]   total_s;
    logic signed [ACC_WIDTH-1:0]   gsum_all_s;
    logic signed [ACC_WIDTH-1:0]   signed_total_s;
    logic signed [ACC_WIDTH-1:0]   col_term_s;
    logic signed [ACC_WIDTH-1:0]   mul_base_s;
    logic signed [ACC_WIDTH-1:0]   mul_term_s;
    logic signed [ACC_WIDTH-1:0]   beat_term_s;

    // Group sums of the latched tile; captured into gsum_r during LOAD.
    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            logic signed [GSUM_WIDTH-1:0] sum_v;
            sum_v = {GSUM_WIDTH{1'b0}};
            for (int j = 0; j < GROUP_SIZE; j++) begin
                sum_v = sum_v + GSUM_WIDTH'(act_r[g*GROUP_SIZE + j]);
            end
            gsum_s[g] = sum_v;
        end
    end

    // Column datapath: selector windows, skip-zero complement, sign/shift and multiplier term.
    always_comb begin
        total_s    = ACC_ZERO;
        gsum_all_s = ACC_ZERO;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            logic signed [ACC_WIDTH-1:0] psum_v;
            logic signed [ACC_WIDTH-1:0] gsum_v;
            gsum_v = ACC_WIDTH'(gsum_r[g]);
            psum_v = ACC_ZERO;
            for (int k = 0; k < HALF; k++) begin
                // Offsets beyond HALF match no window position and so contribute nothing.
                for (int sv = 0; sv <= HALF; sv++) begin
                    psum_v = psum_v +
                        ((col_val[g*HALF + k] && (col_sel[g*HALF + k] == SEL_WIDTH'(sv)))
                            ? ACC_WIDTH'(act_r[g*GROUP_SIZE + k + sv]) : ACC_ZERO);
                end
            end
            total_s    = total_s + (col_skip_zero[g] ? psum_v : (gsum_v - psum_v));
            gsum_all_s = gsum_all_s + gsum_v;
        end
        signed_total_s = (cnt_r == CNT_WIDTH'(W_BITS - 1)) ? -total_s : total_s;
        col_term_s     = signed_total_s <<< cnt_r;
        mul_base_s     = col_en_mul ? (gsum_all_s * ACC_WIDTH'(col_mul_const)) : ACC_ZERO;
        mul_term_s     = col_shift_mul ? (mul_base_s <<< 3) : mul_base_s;
        beat_term_s    = col_term_s + mul_term_s;
    end

    // Sequencer FSM, two-stage accumulate pipeline and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_WIDTH{1'b0}};
            accum_r      <= ACC_ZERO;
            pipe_term_r  <= ACC_ZERO;
            pipe_valid_r <= 1'b0;
            act_ready_r  <= 1'b1;
            col_ready_r  <= 1'b0;
            res_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            for (int i = 0; i < VEC_LENGTH; i++) begin
                act_r[i] <= {DATA_WIDTH{1'b0}};
            end
            for (int g = 0; g < NUM_GROUPS; g++) begin
                gsum_r[g] <= {GSUM_WIDTH{1'b0}};
            end
        end else begin
            pipe_valid_r <= 1'b0;
            if (pipe_valid_r) begin
                accum_r <= accum_r + pipe_term_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (act_valid && act_ready_r) begin
                        act_r       <= act_in;
                        accum_r     <= accum_init;
                        cnt_r       <= CNT_WIDTH'(W_BITS - 1);
                        state_r     <= ST_LOAD;
                        act_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    gsum_r      <= gsum_s;
                    state_r     <= ST_COL;
                    col_ready_r <= 1'b1;
                end
                ST_COL: begin
                    if (col_valid && col_ready_r) begin
                        pipe_term_r  <= beat_term_s;
                        pipe_valid_r <= 1'b1;
                        if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                            state_r     <= ST_DRAIN;
                            col_ready_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r - CNT_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last term lands in accum_r the cycle after the final beat.
                    if (!pipe_valid_r) begin
                        state_r     <= ST_DONE;
                        res_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_r     <= ST_IDLE;
                        res_valid_r <= 1'b0;
                        act_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    pipe_valid_r <= 1'b0;
                    act_ready_r  <= 1'b1;
                    col_ready_r  <= 1'b0;
                    res_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign act_ready = act_ready_r;
    assign col_ready = col_ready_r;
    assign res_valid = res_valid_r;
    assign busy      = busy_r;
    assign accum_out = accum_r;
    assign result    = accum_r[ACC_WIDTH-1 -: RESULT_WIDTH];

endmodule
